jpeg_frame_ctrl: RTL and testbench

Frame-level sequencer wrapped around jpeg_encoder. On start it streams a fixed JPEG header from an external header ROM. It then admits exactly MCUS*64 zigzag-ordered coefficients into the encoder and forwards the encoder's 32-bit words. Once the encoder pipeline has drained, it appends the EOI trailer word. This keeps the encoder's internal pixel/MCU counters and DC predictor frame-aligned and gives downstream a single framed 32-bit stream.

---
 rtl/jpeg_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_jpeg_frame_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer around jpeg_encoder: header from ROM, MCUS*64 coefficients,
// encoder words forwarded, then an EOI trailer once the encoder has gone quiet.
module jpeg_frame_ctrl #(
  parameter int HDR_WORDS    = 156,
  parameter int MCUS         = 256,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic [7:0]                   coef_in,
  input  logic                         coef_valid,
  output logic                         coef_ready,
  output logic [$clog2(HDR_WORDS)-1:0] hdr_addr,
  input  logic [31:0]                  hdr_data,
  output logic [7:0]                   enc_din,
  output logic                         enc_din_valid,
  input  logic [31:0]                  enc_dout,
  input  logic                         enc_dout_valid,
  output logic [31:0]                  dout,
  output logic                         dout_valid,
  output logic                         dout_last,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_overlap
);
  localparam int AW = $clog2(HDR_WORDS);
  localparam int IW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [13:0]   COEF_LAST = 14'(MCUS * 64 - 1);
  localparam logic [13:0]   HDR_LAST  = 14'(HDR_WORDS);
  localparam logic [AW-1:0] ADDR_LAST = AW'(HDR_WORDS - 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(DRAIN_CYCLES);
  localparam logic [31:0]   EOI_WORD  = {16'hFFD9, 16'h0000};

  typedef enum logic [2:0] {IDLE, HEADER, STREAM, DRAIN, TRAILER} state_t;

  state_t        state_reg, state_next;
  logic [13:0]   cnt_reg, cnt_next;
  logic [AW-1:0] hdr_addr_reg, hdr_addr_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic [31:0]   dout_reg, dout_next;
  logic          dout_valid_reg, dout_valid_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hdr_addr_reg   <= '0;
      idle_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      hdr_addr_reg   <= hdr_addr_next;
      idle_reg       <= idle_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    hdr_addr_next   = hdr_addr_reg;
    idle_next       = idle_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    err_next        = err_reg;
    coef_ready      = 1'b0;
    enc_din_valid   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = HEADER;
          hdr_addr_next = '0;
          cnt_next      = '0;
          err_next      = 1'b0;
        end
      end
      HEADER: begin
        if (hdr_addr_reg != ADDR_LAST) hdr_addr_next = hdr_addr_reg + 1'b1;
        // ROM data lags the address by one cycle, so word k lands at count k+1.
        if (cnt_reg != 14'd0) begin
          dout_next       = hdr_data;
          dout_valid_next = 1'b1;
        end
        if (cnt_reg == HDR_LAST) begin
          state_next = STREAM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 14'd1;
        end
      end
      STREAM: begin
        coef_ready    = 1'b1;
        enc_din_valid = coef_valid;
        if (enc_dout_valid) begin
          dout_next       = enc_dout;
          dout_valid_next = 1'b1;
        end
        if (coef_valid) begin
          cnt_next = cnt_reg + 14'd1;
          if (cnt_reg == COEF_LAST) begin
            state_next = DRAIN;
            idle_next  = IDLE_LOAD;
          end
        end
      end
      DRAIN: begin
        if (enc_dout_valid) begin
          dout_next       = enc_dout;
          dout_valid_next = 1'b1;
          idle_next       = IDLE_LOAD;
        end else if (idle_reg <= IW'(1)) begin
          // Trailer is registered on the edge the quiet count expires.
          state_next      = TRAILER;
          idle_next       = '0;
          dout_next       = EOI_WORD;
          dout_valid_next = 1'b1;
        end else begin
          idle_next = idle_reg - 1'b1;
        end
      end
      TRAILER: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (enc_dout_valid &&
        (state_reg == IDLE || state_reg == HEADER || state_reg == TRAILER))
      err_next = 1'b1;
  end

  assign enc_din     = coef_in;
  assign hdr_addr    = hdr_addr_reg;
  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign dout_last   = (state_reg == TRAILER);
  assign frame_done  = (state_reg == TRAILER);
  assign busy        = (state_reg != IDLE);
  assign err_overlap = err_reg;

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Bench for jpeg_frame_ctrl: mid-header reset, two framed runs with random
// coefficient gaps and a stub encoder, checked against a frame-timeline model.
module tb_jpeg_frame_ctrl;
  localparam int HDR_WORDS    = 156;
  localparam int MCUS         = 256;
  localparam int DRAIN_CYCLES = 16;
  localparam int TOTAL        = MCUS * 64;
  localparam int LAST_GAP     = 5;
  localparam int FRAME_LIMIT  = 40000;
  localparam logic [31:0] EOI_WORD = 32'hFFD90000;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [7:0]  coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [7:0]  hdr_addr;
  logic [31:0] hdr_data;
  logic [7:0]  enc_din;
  logic        enc_din_valid;
  logic [31:0] enc_dout;
  logic        enc_dout_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic        frame_done;
  logic        err_overlap;

  int checks = 0;
  int errors = 0;

  jpeg_frame_ctrl #(
    .HDR_WORDS(HDR_WORDS), .MCUS(MCUS), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .enc_din(enc_din), .enc_din_valid(enc_din_valid),
    .enc_dout(enc_dout), .enc_dout_valid(enc_dout_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .busy(busy), .frame_done(frame_done), .err_overlap(err_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header ROM: word[i] = i, one cycle read latency.
  always @(posedge clk) hdr_data <= {24'd0, hdr_addr};

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check32({tag, "_dout"}, dout, 32'd0);
    check1({tag, "_dout_valid"}, dout_valid, 1'b0);
    check1({tag, "_dout_last"}, dout_last, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_frame_done"}, frame_done, 1'b0);
    check1({tag, "_err_overlap"}, err_overlap, 1'b0);
    check1({tag, "_coef_ready"}, coef_ready, 1'b0);
    check1({tag, "_enc_din_valid"}, enc_din_valid, 1'b0);
    check32({tag, "_hdr_addr"}, 32'(hdr_addr), 32'd0);
  endtask

  // Step i is observed 1 time unit after the i-th edge following the start sample.
  // Timeline: header words at steps 2..HDR_WORDS+1, stream from step HDR_WORDS+1,
  // trailer DRAIN_CYCLES steps after the last encoder word is shown.
  task automatic run_frame(input bit hold_start, input int ovl_step, input bit trail_ovl);
    int accepted, s_last, t_step;
    bit pend_v, err_exp, ovl_prev, done, ev, exp_rdy, exp_dv;
    logic [31:0] pend_w, exp_dout, w;
    accepted = 0; s_last = -1; t_step = -1;
    pend_v = 1'b0; pend_w = '0; err_exp = 1'b0; ovl_prev = 1'b0; done = 1'b0;
    exp_dout = '0;
    for (int i = 0; i < FRAME_LIMIT; i++) begin
      @(posedge clk); #1;
      if (i == 0 && !hold_start) start = 1'b0;
      if (ovl_prev) err_exp = 1'b1;

      if (t_step >= 0 && i == t_step) begin
        exp_dv = 1'b1; exp_dout = EOI_WORD;
      end else if (t_step >= 0 && i == t_step + 1) begin
        exp_dv = 1'b0;
      end else if (i <= HDR_WORDS + 1) begin
        exp_dv = (i >= 2); exp_dout = 32'(i - 2);
      end else begin
        exp_dv = pend_v; exp_dout = pend_w;
      end
      check1("dout_valid", dout_valid, exp_dv);
      if (exp_dv) check32("dout", dout, exp_dout);
      check1("dout_last", dout_last, i == t_step);
      check1("frame_done", frame_done, i == t_step);
      check1("busy", busy, !(t_step >= 0 && i == t_step + 1));
      check1("err_overlap", err_overlap, err_exp);
      if (i <= HDR_WORDS + 1)
        check32("hdr_addr", 32'(hdr_addr), (i < HDR_WORDS) ? 32'(i) : 32'(HDR_WORDS - 1));

      if (t_step >= 0 && i == t_step + 1) begin
        coef_valid = 1'b0; enc_dout_valid = 1'b0; done = 1'b1;
        $display("frame done: trailer at step %0d, last accept at step %0d", t_step, s_last);
        break;
      end

      coef_valid = ($urandom_range(3) != 0);
      coef_in    = 8'($urandom);
      w          = $urandom;
      ev         = 1'b0;
      if (i == ovl_step) ev = 1'b1;
      else if (i >= HDR_WORDS + 1 && accepted < TOTAL) ev = ($urandom_range(7) == 0);
      else if (s_last >= 0 && (i == s_last + 2 || i == s_last + LAST_GAP)) ev = 1'b1;
      else if (trail_ovl && i == t_step) ev = 1'b1;
      enc_dout_valid = ev;
      enc_dout       = w;
      #1;
      exp_rdy = (i >= HDR_WORDS + 1) && (accepted < TOTAL);
      check1("coef_ready", coef_ready, exp_rdy);
      check1("enc_din_valid", enc_din_valid, exp_rdy && coef_valid);
      if (exp_rdy && coef_valid) begin
        check32("enc_din", 32'(enc_din), 32'(coef_in));
        accepted++;
        if (accepted == TOTAL) begin
          s_last = i;
          t_step = i + LAST_GAP + 1 + DRAIN_CYCLES;
        end
      end
      pend_v   = ev;
      pend_w   = w;
      ovl_prev = ev && (i < HDR_WORDS + 1 || i == t_step);
    end
    check1("frame_complete", done, 1'b1);
  endtask

  initial begin
    int waited;
    nrst = 1'b0; start = 1'b0; coef_in = '0; coef_valid = 1'b0;
    enc_dout = '0; enc_dout_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    $display("reset state checked");

    nrst = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waited = 0;
    while (hdr_addr !== 8'd40 && waited < 500) begin
      @(posedge clk); #1; waited++;
    end
    check32("mid_hdr_addr", 32'(hdr_addr), 32'd40);
    nrst = 1'b0; #1;
    check_idle("mid_hdr_reset");
    $display("mid-header reset checked");
    @(posedge clk); #1; nrst = 1'b1;

    // Frame 1: start held high throughout, encoder pulse during the header.
    start = 1'b1;
    run_frame(1'b1, 50, 1'b0);
    // Frame 2: begins from IDLE on the held start; overlap during trailer.
    run_frame(1'b0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
